// File: rtl/trig_pkg.sv
//----------------------------------------------------------------------------
// Module  : trig_pkg
// Brief   : Shared widths, opcode and FSM encodings for the trig scheduler.
// Rev     : 1.0
//----------------------------------------------------------------------------
`default_nettype none

package trig_pkg;

    localparam int ANGLE_W  = 12;
    localparam int RESULT_W = 16;
    localparam logic [ANGLE_W-1:0] ANGLE_90 = 12'd1024;

    localparam logic [1:0] OP_COS  = 2'b00;
    localparam logic [1:0] OP_SIN  = 2'b01;
    localparam logic [1:0] OP_CEXP = 2'b10;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SECOND = 1'b1
    } state_e;

    // sin(a) = cos(90deg - a); 12-bit wrap gives the modulo-4096 result.
    function automatic logic [ANGLE_W-1:0] sin_angle(input logic [ANGLE_W-1:0] a);
        return ANGLE_90 - a;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
//----------------------------------------------------------------------------
// Module  : rr_arbiter
// Brief   : Round-robin pick searching upward from ptr with wrap.
// Rev     : 1.0
//----------------------------------------------------------------------------
`default_nettype none

module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = 3
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx,
    output logic            found
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0] cand;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        if (en) begin
            for (int i = 0; i < NREQ; i++) begin
                cand = PW'((int'(ptr) + i) % NREQ);
                if (!found && req[cand]) begin
                    found     = 1'b1;
                    gnt[cand] = 1'b1;
                    idx       = IDW'(cand);
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/trig_sched.sv
//----------------------------------------------------------------------------
// Module  : trig_sched
// Brief   : Round-robin scheduler sharing one cos lookup among NREQ users.
// Rev     : 1.0
//----------------------------------------------------------------------------
`default_nettype none

module trig_sched
    import trig_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [2*NREQ-1:0]        req_op,
    input  logic [ANGLE_W*NREQ-1:0]  req_angle,
    output logic [NREQ-1:0]          gnt,
    output logic [ANGLE_W-1:0]       cm_angle,
    input  logic [RESULT_W-1:0]      cm_result,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [RESULT_W-1:0]      rsp_data,
    output logic [IDW-1:0]           rsp_id,
    output logic                     rsp_sin,
    output logic                     rsp_last
);

    state_e               state_q, state_d;
    logic                 adv;
    logic                 accept;
    logic [IDW-1:0]       rr_ptr;
    logic [IDW-1:0]       grant_idx;
    logic                 found;
    logic [1:0]           sel_op;
    logic [ANGLE_W-1:0]   sel_angle;
    logic [ANGLE_W-1:0]   lat_angle;
    logic [IDW-1:0]       lat_id;
    logic                 s1_valid;
    logic [IDW-1:0]       s1_id;
    logic                 s1_sin;
    logic                 s1_last;

    assign adv    = !rsp_valid | rsp_ready;
    assign accept = |(req & gnt);

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req   (req),
        .ptr   (rr_ptr),
        .en    (adv && (state_q == ST_IDLE)),
        .gnt   (gnt),
        .idx   (grant_idx),
        .found (found)
    );

    // Operand mux keyed only by the arbiter index, so gnt never sees op/angle.
    always_comb begin
        sel_op    = OP_COS;
        sel_angle = '0;
        for (int n = 0; n < NREQ; n++) begin
            if (int'(grant_idx) == n) begin
                sel_op    = req_op[2*n +: 2];
                sel_angle = req_angle[ANGLE_W*n +: ANGLE_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept && sel_op == OP_CEXP) state_d = ST_SECOND;
            ST_SECOND: if (adv) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= '0;
            cm_angle  <= '0;
            lat_angle <= '0;
            lat_id    <= '0;
            s1_valid  <= 1'b0;
            s1_id     <= '0;
            s1_sin    <= 1'b0;
            s1_last   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
            rsp_sin   <= 1'b0;
            rsp_last  <= 1'b0;
        end else if (adv) begin
            if (state_q == ST_SECOND) begin
                cm_angle <= sin_angle(lat_angle);
                s1_valid <= 1'b1;
                s1_id    <= lat_id;
                s1_sin   <= 1'b1;
                s1_last  <= 1'b1;
            end else if (accept) begin
                rr_ptr   <= (int'(grant_idx) == NREQ-1) ? '0 : grant_idx + IDW'(1);
                s1_valid <= 1'b1;
                s1_id    <= grant_idx;
                if (sel_op == OP_SIN) begin
                    cm_angle <= sin_angle(sel_angle);
                    s1_sin   <= 1'b1;
                    s1_last  <= 1'b1;
                end else begin
                    // cexp issues its cos half now and the sin half from SECOND.
                    cm_angle  <= sel_angle;
                    s1_sin    <= 1'b0;
                    s1_last   <= (sel_op != OP_CEXP);
                    lat_angle <= sel_angle;
                    lat_id    <= grant_idx;
                end
            end else begin
                s1_valid <= 1'b0;
            end
            rsp_valid <= s1_valid;
            rsp_data  <= cm_result;
            rsp_id    <= s1_id;
            rsp_sin   <= s1_sin;
            rsp_last  <= s1_last;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_trig_sched.sv
//----------------------------------------------------------------------------
// Module  : tb_trig_sched
// Brief   : Directed self-checking bench for trig_sched with a stand-in ROM.
// Rev     : 1.0
//----------------------------------------------------------------------------
`default_nettype none

module tb_trig_sched;

    localparam int NREQ = 2;
    localparam int IDW  = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [1:0]        op0, op1;
    logic [11:0]       ang0, ang1;
    logic [NREQ-1:0]   gnt;
    logic [11:0]       cm_angle;
    logic [15:0]       cm_result;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [15:0]       rsp_data;
    logic [IDW-1:0]    rsp_id;
    logic              rsp_sin;
    logic              rsp_last;

    int checks = 0;
    int errors = 0;

    // Distinct, easily-predicted stand-in for the cos ROM.
    function automatic logic [15:0] rom(input logic [11:0] a);
        return {a, 4'h5} ^ 16'h0F0F;
    endfunction

    assign cm_result = rom(cm_angle);

    always #5 clk = ~clk;

    trig_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_op    ({op1, op0}),
        .req_angle ({ang1, ang0}),
        .gnt       (gnt),
        .cm_angle  (cm_angle),
        .cm_result (cm_result),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_sin   (rsp_sin),
        .rsp_last  (rsp_last)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rsp(input string tag, input logic v, input logic [15:0] d,
                           input logic [IDW-1:0] id, input logic s, input logic l);
        chk({tag, "_valid"}, 32'(rsp_valid), 32'(v));
        chk({tag, "_data"},  32'(rsp_data),  32'(d));
        chk({tag, "_id"},    32'(rsp_id),    32'(id));
        chk({tag, "_sin"},   32'(rsp_sin),   32'(s));
        chk({tag, "_last"},  32'(rsp_last),  32'(l));
    endtask

    initial begin
        rst = 1'b1; req = '0; op0 = 2'b00; op1 = 2'b00;
        ang0 = '0; ang1 = '0; rsp_ready = 1'b1;
        #1;
        step(); step();
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_cm_angle", 32'(cm_angle), 0);
        chk_rsp("rst", 1'b0, 16'h0, 3'd0, 1'b0, 1'b0);
        rst = 1'b0;

        // single cos on requester 0
        req = 2'b01; op0 = 2'b00; ang0 = 12'd0; #1;
        chk("cos_gnt", 32'(gnt), 32'b01);
        step();
        chk("cos_cm_angle", 32'(cm_angle), 0);
        chk("cos_rsp_not_yet", 32'(rsp_valid), 0);
        req = 2'b00;
        step();
        chk_rsp("cos", 1'b1, rom(12'd0), 3'd0, 1'b0, 1'b1);
        step();
        chk("cos_drain", 32'(rsp_valid), 0);

        // sin wrap on requester 1: 2048 -> 3072, then 4095 -> 1025
        req = 2'b10; op1 = 2'b01; ang1 = 12'd2048; #1;
        chk("sin_gnt", 32'(gnt), 32'b10);
        step();
        chk("sin2048_cm_angle", 32'(cm_angle), 3072);
        ang1 = 12'd4095; #1;
        chk("sin_gnt2", 32'(gnt), 32'b10);
        step();
        chk_rsp("sin2048", 1'b1, rom(12'd3072), 3'd1, 1'b1, 1'b1);
        chk("sin4095_cm_angle", 32'(cm_angle), 1025);
        req = 2'b00;
        step();
        chk_rsp("sin4095", 1'b1, rom(12'd1025), 3'd1, 1'b1, 1'b1);
        step();
        chk("sin_drain", 32'(rsp_valid), 0);

        // fairness: both requesting cos, grants alternate starting at 0
        req = 2'b11; op0 = 2'b00; op1 = 2'b00; ang0 = 12'd100; ang1 = 12'd200;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("fair_gnt", 32'(gnt), (i % 2 == 0) ? 32'b01 : 32'b10);
            step();
            if (i >= 1) begin
                chk("fair_id", 32'(rsp_id), 32'((i - 1) % 2));
                chk("fair_data", 32'(rsp_data), ((i - 1) % 2 == 0) ? 32'(rom(12'd100)) : 32'(rom(12'd200)));
            end
        end
        req = 2'b00;
        step();
        chk_rsp("fair_last", 1'b1, rom(12'd200), 3'd1, 1'b0, 1'b1);
        step();
        chk("fair_drain", 32'(rsp_valid), 0);

        // cexp on requester 0, angle 512; other requester raised during SECOND
        req = 2'b01; op0 = 2'b10; ang0 = 12'd512; #1;
        chk("cexp_gnt", 32'(gnt), 32'b01);
        step();
        chk("cexp_cm_cos", 32'(cm_angle), 512);
        req = 2'b11; op1 = 2'b00; #1;
        chk("cexp_second_gnt", 32'(gnt), 0);
        req = 2'b00;
        step();
        chk_rsp("cexp_cos", 1'b1, rom(12'd512), 3'd0, 1'b0, 1'b0);
        chk("cexp_cm_sin", 32'(cm_angle), 512);
        step();
        chk_rsp("cexp_sin", 1'b1, rom(12'd512), 3'd0, 1'b1, 1'b1);
        step();
        chk("cexp_drain", 32'(rsp_valid), 0);

        // backpressure: rr_ptr=1, so requester 1 wins first
        req = 2'b11; op0 = 2'b00; op1 = 2'b00; ang0 = 12'd100; ang1 = 12'd200; #1;
        chk("bp_gnt_a", 32'(gnt), 32'b10);
        step();
        rsp_ready = 1'b0; #1;
        chk("bp_gnt_b", 32'(gnt), 32'b01);
        step();
        for (int i = 0; i < 3; i++) begin
            chk("bp_stall_gnt", 32'(gnt), 0);
            chk_rsp("bp_stall", 1'b1, rom(12'd200), 3'd1, 1'b0, 1'b1);
            chk("bp_stall_cm", 32'(cm_angle), 100);
            step();
        end
        req = 2'b00; rsp_ready = 1'b1;
        step();
        chk_rsp("bp_resume", 1'b1, rom(12'd100), 3'd0, 1'b0, 1'b1);
        step();
        chk("bp_drain", 32'(rsp_valid), 0);

        // reset in the SECOND cycle of a cexp on requester 0 (rr_ptr=1 -> 1)
        req = 2'b01; op0 = 2'b10; ang0 = 12'd300; #1;
        chk("rstc_gnt", 32'(gnt), 32'b01);
        step();
        rst = 1'b1; req = 2'b00;
        step();
        chk("rstc_cm", 32'(cm_angle), 0);
        chk_rsp("rstc", 1'b0, 16'h0, 3'd0, 1'b0, 1'b0);
        rst = 1'b0;
        step();
        chk("rstc_no_sin1", 32'(rsp_valid), 0);
        step();
        chk("rstc_no_sin2", 32'(rsp_valid), 0);
        req = 2'b11; op0 = 2'b00; op1 = 2'b00; #1;
        chk("rstc_ptr0_gnt", 32'(gnt), 32'b01);
        req = 2'b00;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
